// File: rtl/write_info.sv
// write_info: queues {pu_id, size} write requests and drains size+1 beats per request from the addressed PU FIFO into outbuf; optional WRITE_INFO_DONE_EN adds per-request completion outputs
module write_info #(
    parameter int NUM_PU      = 1,
    parameter int WR_SIZE_W   = 20,
    parameter int PU_ID_W     = $clog2(NUM_PU) + 1,
    parameter int REQ_FIFO_AW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_req,
    input  logic [WR_SIZE_W-1:0] wr_req_size,
    input  logic [PU_ID_W-1:0]   wr_req_pu_id,
    output logic                 write_info_full,
    input  logic [NUM_PU-1:0]    pu_empty,
    output logic [NUM_PU-1:0]    pu_pop,
    input  logic                 outbuf_almost_full,
    output logic                 outbuf_push,
    output logic [PU_ID_W-1:0]   outbuf_pu_id,
`ifdef WRITE_INFO_DONE_EN
    output logic                 wr_done,
    output logic [PU_ID_W-1:0]   wr_done_pu_id,
`endif
    output logic                 busy
);
    localparam int DEPTH = 1 << REQ_FIFO_AW;
    localparam int ENT_W = PU_ID_W + WR_SIZE_W;
    localparam logic [REQ_FIFO_AW:0] PTR_ONE = 1;
    localparam logic [WR_SIZE_W-1:0] CNT_ONE = 1;
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_n;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [REQ_FIFO_AW:0] wr_ptr, rd_ptr;
    logic [PU_ID_W-1:0] cur_pu_id, head_pu_id;
    logic [WR_SIZE_W-1:0] cur_size, head_size, count;
    logic fifo_empty, req_push, req_pop, head_ok, sel_empty, beat, last, load;

    assign fifo_empty = wr_ptr == rd_ptr;
    assign write_info_full = (wr_ptr[REQ_FIFO_AW] != rd_ptr[REQ_FIFO_AW]) &&
                             (wr_ptr[REQ_FIFO_AW-1:0] == rd_ptr[REQ_FIFO_AW-1:0]);
    assign req_push = wr_req && !write_info_full;
    assign {head_pu_id, head_size} = mem[rd_ptr[REQ_FIFO_AW-1:0]];
    assign head_ok = head_pu_id < PU_ID_W'(NUM_PU);
    assign busy = state == ACTIVE || !fifo_empty;

    // Empty flag of the PU currently being drained
    always_comb begin
        sel_empty = 1'b0;
        for (int i = 0; i < NUM_PU; i++) sel_empty = sel_empty | (pu_empty[i] && cur_pu_id == PU_ID_W'(i));
    end

    // Beat qualification, next state and request pop; out-of-range PU ids are consumed without loading
    always_comb begin
        beat    = !reset && state == ACTIVE && !sel_empty && !outbuf_almost_full;
        last    = beat && count == cur_size;
        req_pop = !fifo_empty && (state == IDLE || last);
        load    = req_pop && head_ok;
        state_n = load ? ACTIVE : (state == IDLE || last) ? IDLE : ACTIVE;
        pu_pop  = '0;
        for (int i = 0; i < NUM_PU; i++) pu_pop[i] = beat && cur_pu_id == PU_ID_W'(i);
    end

    // State register
    always_ff @(posedge clk) state <= reset ? IDLE : state_n;

    // Request FIFO storage needs no reset; pointers define validity
    always_ff @(posedge clk) if (req_push) mem[wr_ptr[REQ_FIFO_AW-1:0]] <= {wr_req_pu_id, wr_req_size};

    // Request FIFO pointers, current request and beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cur_pu_id <= '0;
            cur_size  <= '0;
            count     <= '0;
        end else begin
            if (req_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (req_pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (load) begin
                cur_pu_id <= head_pu_id;
                cur_size  <= head_size;
            end
            count <= (load || last) ? '0 : beat ? count + CNT_ONE : count;
        end
    end

    // Outbuf push trails the pop by one cycle, when the PU FIFO data becomes valid
    always_ff @(posedge clk) begin
        if (reset) begin
            outbuf_push  <= 1'b0;
            outbuf_pu_id <= '0;
        end else begin
            outbuf_push <= beat;
            if (beat) outbuf_pu_id <= cur_pu_id;
        end
    end

`ifdef WRITE_INFO_DONE_EN
    // Completion pulse aligned with the push of each request's last beat
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_done       <= 1'b0;
            wr_done_pu_id <= '0;
        end else begin
            wr_done <= last;
            if (last) wr_done_pu_id <= cur_pu_id;
        end
    end
`endif

endmodule

// File: tb/tb_write_info.sv
// tb_write_info: randomized bench for write_info against a beat-sequence reference model
module tb_write_info;
    localparam int NUM_PU = 4, WR_SIZE_W = 4, PU_ID_W = 3;
    logic clk = 0, reset = 1, wr_req = 0, outbuf_almost_full = 0;
    logic [WR_SIZE_W-1:0] wr_req_size = '0;
    logic [PU_ID_W-1:0] wr_req_pu_id = '0;
    logic [NUM_PU-1:0] pu_empty = '1;
    logic [NUM_PU-1:0] pu_pop;
    logic write_info_full, outbuf_push, busy;
    logic [PU_ID_W-1:0] outbuf_pu_id;
`ifdef WRITE_INFO_DONE_EN
    logic wr_done;
    logic [PU_ID_W-1:0] wr_done_pu_id;
    int dones = 0;
`endif
    typedef struct {int pu; bit last;} beat_t;
    beat_t exp_q[$];
    int n_chk = 0, n_pass = 0;
    int pops = 0, first_cyc = -1, last_cyc = -1, cyc = 0, prev_pu = -1;
    bit prev_last = 0, stall_en = 0;

    always #5 clk = ~clk;

    write_info #(.NUM_PU(NUM_PU), .WR_SIZE_W(WR_SIZE_W), .PU_ID_W(PU_ID_W), .REQ_FIFO_AW(5)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_req_size(wr_req_size),
        .wr_req_pu_id(wr_req_pu_id), .write_info_full(write_info_full), .pu_empty(pu_empty),
        .pu_pop(pu_pop), .outbuf_almost_full(outbuf_almost_full), .outbuf_push(outbuf_push),
        .outbuf_pu_id(outbuf_pu_id),
`ifdef WRITE_INFO_DONE_EN
        .wr_done(wr_done), .wr_done_pu_id(wr_done_pu_id),
`endif
        .busy(busy));

    task automatic check(string tag, longint got, longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        pops = 0;
        first_cyc = -1;
        last_cyc = -1;
    endtask

    // Reference model: each accepted in-range request expands to size+1 beats of its PU, in order
    task automatic send(int pu, int size, output bit acc);
        wr_req = 1;
        wr_req_pu_id = PU_ID_W'(pu);
        wr_req_size = WR_SIZE_W'(size);
        acc = !write_info_full;
        if (acc && pu < NUM_PU)
            for (int k = 0; k <= size; k++) exp_q.push_back('{pu, k == size});
        tick();
        wr_req = 0;
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || busy); i++) tick();
        tick();
        check(tag, exp_q.size() == 0 && !busy, 1);
    endtask

    task automatic stall_loop();
        while (stall_en) begin
            pu_empty = 4'($urandom);
            outbuf_almost_full = ($urandom % 4) == 0;
            tick();
        end
    endtask

    // Monitor: pops against the model, pushes one cycle behind the pops
    always @(negedge clk) begin
        int pu;
        cyc++;
        if (reset) begin
            check("pop_in_reset", pu_pop, 0);
            exp_q.delete();
            prev_pu = -1;
        end else begin
            check("push_lat", outbuf_push, prev_pu >= 0);
            if (prev_pu >= 0) check("push_id", outbuf_pu_id, prev_pu);
`ifdef WRITE_INFO_DONE_EN
            check("done", wr_done, prev_pu >= 0 && prev_last);
            if (wr_done) begin
                dones++;
                check("done_id", wr_done_pu_id, prev_pu);
            end
`endif
            prev_pu = -1;
            if (pu_pop != 0) begin
                pu = 0;
                for (int i = 0; i < NUM_PU; i++) if (pu_pop[i]) pu = i;
                check("pop_onehot", $onehot(pu_pop), 1);
                check("pop_while_empty", pu_empty[pu], 0);
                check("pop_while_af", outbuf_almost_full, 0);
                check("pop_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("pop_pu", pu, exp_q[0].pu);
                    prev_last = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
                prev_pu = pu;
                pops++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int cnt;
        tick(3);
        reset = 0;
        check("rst_full", write_info_full, 0);
        check("rst_busy", busy, 0);
        check("rst_push", outbuf_push, 0);
        check("rst_pu_id", outbuf_pu_id, 0);
        check("rst_pop", pu_pop, 0);
        // Single request, free-flowing PU
        pu_empty = '0;
        clr();
        send(2, 3, acc);
        drain("t1_drain");
        check("t1_pops", pops, 4);
        check("t1_span", last_cyc - first_cyc + 1, 4);
        check("t1_busy", busy, 0);
        // Back-to-back requests with no idle cycle between them
        clr();
        send(0, 0, acc);
        send(1, 1, acc);
        drain("t2_drain");
        check("t2_pops", pops, 3);
        check("t2_span", last_cyc - first_cyc + 1, 3);
        // Stalls mid-request
        clr();
        send(1, 7, acc);
        for (int i = 0; i < 300 && pops < 8; i++) begin
            pu_empty[1] = 1'($urandom);
            outbuf_almost_full = ($urandom % 3) == 0;
            tick();
        end
        pu_empty = '0;
        outbuf_almost_full = 0;
        drain("t3_drain");
        check("t3_pops", pops, 8);
        // Fill with all PUs stalled: one request is held active, 32 queued
        pu_empty = '1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            send(i % NUM_PU, int'($urandom_range(0, 3)), acc);
            if (acc) cnt++;
        end
        check("t4_accepted", cnt, 33);
        check("t4_full", write_info_full, 1);
        pu_empty = '0;
        drain("t4_drain");
        check("t4_full_clear", write_info_full, 0);
        // Reset at beat 2 of a size-5 request
        clr();
        send(3, 5, acc);
        for (int i = 0; i < 50 && pops < 2; i++) tick();
        check("t5_reached", pops, 2);
        reset = 1;
        tick();
        reset = 0;
        check("t5_pop", pu_pop, 0);
        check("t5_push", outbuf_push, 0);
        check("t5_busy", busy, 0);
        clr();
        send(0, 2, acc);
        drain("t5_drain");
        check("t5_pops", pops, 3);
        // Maximum size and an out-of-range PU id that must be dropped
        clr();
        send(1, 15, acc);
        drain("max_drain");
        check("max_pops", pops, 16);
        clr();
        send(5, 3, acc);
        send(2, 0, acc);
        drain("bad_drain");
        check("bad_pops", pops, 1);
`ifdef WRITE_INFO_DONE_EN
        dones = 0;
        send(3, 2, acc);
        drain("t6_drain");
        check("t6_dones", dones, 1);
`endif
        // Random traffic under random stalls
        stall_en = 1;
        fork
            stall_loop();
        join_none
        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)), acc);
            tick(int'($urandom_range(0, 3)));
        end
        stall_en = 0;
        tick(2);
        pu_empty = '0;
        outbuf_almost_full = 0;
        drain("rand_drain");
        check("rand_busy", busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
